// File: rtl/piperg_pkg.sv
// Shared definitions for the pipeline stage registers: the stage-slot state
// encoding, default payload widths and the control-word field positions that
// every stage instance agrees on.
package piperg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 16;

  // Control-word layout shared by the IF/ID, ID/EX, EX/MEM and MEM/WB stages
  localparam int CTRL_MEMWR_BIT = 0;
  localparam int CTRL_REGWR_BIT = 1;
  localparam int CTRL_WBSEL_LSB = 2;
  localparam int CTRL_WBSEL_W   = 2;
  localparam int CTRL_FUNC3_LSB = 4;
  localparam int CTRL_FUNC3_W   = 3;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer for a pipeline stage register. It holds the
// instruction that was accepted while the downstream stage stalled, together
// with an occupied flag. A clear (flush) empties it without touching the data.
module pipe_skid_buf
  import piperg_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              pop,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              full,
  output logic [CTRL_W-1:0] skid_ctrl,
  output logic [DATA_W-1:0] skid_data
);

  // Occupied flag: reset and clear win, then a capture, then a drain
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // Payload storage, only written when a stalled instruction is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and a
// bubble control value forced whenever the output slot is empty.
// Optional feature macro: PIPEREG_SKID_EN. When defined, a one-entry skid
// buffer is built and in_ready is a decode of the registered state; when
// undefined, in_ready = out_ready | ~out_valid and skid_full is tied low.
module pipe_stage_reg
  import piperg_pkg::*;
#(
  parameter int                DATA_W      = PIPE_DATA_W,
  parameter int                CTRL_W      = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              skid_full
);

  pipe_state_e state;
  pipe_state_e state_n;
  logic        transfer;
  logic        load_out;

  assign transfer  = in_valid & in_ready;
  assign out_valid = (state != ST_EMPTY);

`ifdef PIPEREG_SKID_EN
  logic              skid_load;
  logic              load_from_skid;
  logic              skid_occ;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready  = (state != ST_FULL);
  assign skid_full = skid_occ;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (skid_load),
    .pop       (load_from_skid),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .full      (skid_occ),
    .skid_ctrl (skid_ctrl),
    .skid_data (skid_data)
  );
`else
  assign in_ready  = out_ready | ~out_valid;
  assign skid_full = 1'b0;
`endif

  // Next-state and load decisions; flush overrides every handshake outcome
  always_comb begin
    state_n  = state;
    load_out = 1'b0;
`ifdef PIPEREG_SKID_EN
    skid_load      = 1'b0;
    load_from_skid = 1'b0;
`endif
    case (state)
      ST_EMPTY: begin
        if (transfer) begin
          load_out = 1'b1;
          state_n  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (out_ready) begin
          if (transfer) begin
            load_out = 1'b1;
          end else begin
            state_n = ST_EMPTY;
          end
        end
`ifdef PIPEREG_SKID_EN
        else if (transfer) begin
          skid_load = 1'b1;
          state_n   = ST_FULL;
        end
`endif
      end
      ST_FULL: begin
`ifdef PIPEREG_SKID_EN
        if (out_ready) begin
          load_from_skid = 1'b1;
          state_n        = ST_BUSY;
        end
`else
        state_n = ST_EMPTY;
`endif
      end
      default: state_n = ST_EMPTY;
    endcase
    if (flush) begin
      state_n  = ST_EMPTY;
      load_out = 1'b0;
`ifdef PIPEREG_SKID_EN
      skid_load      = 1'b0;
      load_from_skid = 1'b0;
`endif
    end
  end

  // State and output slot; an emptied slot shows the bubble, data just holds
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      out_ctrl <= CTRL_BUBBLE;
      out_data <= '0;
    end else begin
      state <= state_n;
      if (load_out) begin
        out_ctrl <= in_ctrl;
        out_data <= in_data;
      end
`ifdef PIPEREG_SKID_EN
      else if (load_from_skid) begin
        out_ctrl <= skid_ctrl;
        out_data <= skid_data;
      end
`endif
      else if (state_n == ST_EMPTY) begin
        out_ctrl <= CTRL_BUBBLE;
      end
    end
  end

endmodule
